// File: rtl/pp_axis_to_mat.sv
// Pops one (rows, cols) pair, then moves exactly rows*cols AXI4-Stream pixels
// into the image FIFO under an ap_ctrl_chain block handshake.
module pp_axis_to_mat #(
  parameter int DATA_W = 24,
  parameter int ROWS_W = 16,
  parameter int COLS_W = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  input  logic              ap_continue,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [ROWS_W-1:0] rows_dout,
  input  logic              rows_empty_n,
  output logic              rows_read,
  input  logic [COLS_W-1:0] cols_dout,
  input  logic              cols_empty_n,
  output logic              cols_read,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] img_din,
  input  logic              img_full_n,
  output logic              img_write,
  output logic              tlast_err
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t            state_q, state_d;
  logic [ROWS_W-1:0] rows_q, rows_d, row_q, row_d;
  logic [COLS_W-1:0] cols_q, cols_d, col_q, col_d;
  logic              tlast_err_q, tlast_err_d;
  logic              last_col, last_row, beat;

  assign img_din   = s_axis_tdata;
  assign tlast_err = tlast_err_q;

  // Zero dimensions never reach STREAM, so the minus-one compares cannot wrap.
  assign last_col = (col_q == cols_q - COLS_W'(1));
  assign last_row = (row_q == rows_q - ROWS_W'(1));

  always_comb begin
    state_d       = state_q;
    rows_d        = rows_q;
    cols_d        = cols_q;
    row_d         = row_q;
    col_d         = col_q;
    tlast_err_d   = tlast_err_q;
    ap_done       = 1'b0;
    ap_idle       = 1'b0;
    ap_ready      = 1'b0;
    rows_read     = 1'b0;
    cols_read     = 1'b0;
    s_axis_tready = 1'b0;
    img_write     = 1'b0;
    beat          = 1'b0;
    case (state_q)
      IDLE: begin
        ap_idle = ~ap_start;
        // The pop is masked while reset is held so no FIFO is drained mid-reset.
        if (ap_rst_n && ap_start && rows_empty_n && cols_empty_n) begin
          rows_read = 1'b1;
          cols_read = 1'b1;
          ap_ready  = 1'b1;
          rows_d    = rows_dout;
          cols_d    = cols_dout;
          row_d     = '0;
          col_d     = '0;
          state_d   = (rows_dout == '0 || cols_dout == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        s_axis_tready = img_full_n;
        beat          = s_axis_tvalid && img_full_n;
        img_write     = beat;
        if (beat) begin
          if (s_axis_tlast != last_col)
            tlast_err_d = 1'b1;
          if (last_col) begin
            col_d = '0;
            if (last_row)
              state_d = DONE;
            else
              row_d = row_q + ROWS_W'(1);
          end else begin
            col_d = col_q + COLS_W'(1);
          end
        end
      end
      DONE: begin
        ap_done = 1'b1;
        if (ap_continue)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      tlast_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      row_q       <= row_d;
      col_q       <= col_d;
      tlast_err_q <= tlast_err_d;
    end
  end

endmodule

// File: tb/tb_pp_axis_to_mat.sv
// Scenario bench for pp_axis_to_mat: pixels are scoreboarded as they are offered
// and checked by a monitor on each img_write.
module tb_pp_axis_to_mat;
  localparam int DATA_W = 24;
  localparam int ROWS_W = 16;
  localparam int COLS_W = 32;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n;
  logic              ap_start, ap_done, ap_continue, ap_idle, ap_ready;
  logic [ROWS_W-1:0] rows_dout;
  logic              rows_empty_n, rows_read;
  logic [COLS_W-1:0] cols_dout;
  logic              cols_empty_n, cols_read;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DATA_W-1:0] img_din;
  logic              img_full_n, img_write, tlast_err;

  int errors = 0;
  int checks = 0;
  int ready_seen = 0;
  int writes_seen = 0;
  logic [DATA_W-1:0] exp_q[$];

  pp_axis_to_mat #(.DATA_W(DATA_W), .ROWS_W(ROWS_W), .COLS_W(COLS_W)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
    .ap_continue(ap_continue), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .rows_dout(rows_dout), .rows_empty_n(rows_empty_n), .rows_read(rows_read),
    .cols_dout(cols_dout), .cols_empty_n(cols_empty_n), .cols_read(cols_read),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .img_din(img_din), .img_full_n(img_full_n), .img_write(img_write),
    .tlast_err(tlast_err)
  );

  always #5 ap_clk = ~ap_clk;

  // Scoreboard monitor: every push into the image FIFO must match the oldest offered pixel.
  always @(negedge ap_clk) begin
    logic [DATA_W-1:0] exp_v;
    if (ap_ready) ready_seen++;
    if (img_write) begin
      writes_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL img_extra: img_din=%h written with nothing expected", img_din);
      end else begin
        exp_v = exp_q.pop_front();
        if (img_din !== exp_v) begin
          errors++;
          $display("FAIL img_data: img_din=%h expected %h", img_din, exp_v);
        end else begin
          $display("pixel %h written", img_din);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic load_dims(input int r, input int c);
    rows_dout    = ROWS_W'(r);
    cols_dout    = COLS_W'(c);
    rows_empty_n = 1'b1;
    cols_empty_n = 1'b1;
    ap_start     = 1'b1;
  endtask

  // Wait for the dimension pop, check it, then model the FIFOs going empty.
  task automatic wait_pop();
    bit got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge ap_clk);
      if (rows_read) begin got = 1; break; end
      tick();
    end
    checks++;
    if (!got || cols_read !== 1'b1 || ap_ready !== 1'b1 || ap_idle !== 1'b0) begin
      errors++;
      $display("FAIL dim_pop: got=%0d cols_read=%b ap_ready=%b ap_idle=%b expected 1 1 1 0",
               got, cols_read, ap_ready, ap_idle);
    end else begin
      $display("dims popped rows=%0d cols=%0d", rows_dout, cols_dout);
    end
    tick();
    rows_empty_n = 1'b0;
    cols_empty_n = 1'b0;
    ap_start     = 1'b0;
  endtask

  task automatic start_frame(input int r, input int c);
    load_dims(r, c);
    wait_pop();
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic last);
    bit got = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    exp_q.push_back(d);
    for (int n = 0; n < 20; n++) begin
      @(negedge ap_clk);
      if (img_write) begin got = 1; break; end
      tick();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL beat_timeout: pixel %h not accepted within 20 cycles", d);
    end
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic check_done_then_idle(input string name);
    @(negedge ap_clk);
    checks++;
    if (ap_done !== 1'b1 || s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: ap_done=%b tready=%b expected 1 0", name, ap_done, s_axis_tready);
    end
    tick();
    @(negedge ap_clk);
    checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: ap_idle=%b ap_done=%b expected 1 0", name, ap_idle, ap_done);
    end else begin
      $display("%s frame complete, back in IDLE", name);
    end
    tick();
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0; ap_start = 1'b0; ap_continue = 1'b0;
    rows_dout = '0; cols_dout = '0; rows_empty_n = 1'b0; cols_empty_n = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; img_full_n = 1'b1;
    #2;
    checks++;
    if ({ap_done, ap_ready, rows_read, cols_read, s_axis_tready, img_write, tlast_err, ap_idle} !== 8'b0000_0001) begin
      errors++;
      $display("FAIL reset_state: done/ready/rr/cr/tready/wr/err/idle=%b expected 00000001",
               {ap_done, ap_ready, rows_read, cols_read, s_axis_tready, img_write, tlast_err, ap_idle});
    end
    @(posedge ap_clk); @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int r0 = ready_seen;
    int w0 = writes_seen;
    ap_continue = 1'b1;
    start_frame(2, 3);
    for (int i = 0; i < 6; i++) send_beat(DATA_W'(32'h10 + i), (i == 2 || i == 5));
    checks++;
    if (tlast_err !== 1'b0 || ready_seen - r0 != 1 || writes_seen - w0 != 6) begin
      errors++;
      $display("FAIL basic_counts: tlast_err=%b ready=%0d writes=%0d expected 0 1 6",
               tlast_err, ready_seen - r0, writes_seen - w0);
    end
    check_done_then_idle("basic");
  endtask

  task automatic test_zero_rows();
    s_axis_tvalid = 1'b1;
    start_frame(0, 5);
    check_done_then_idle("zero_rows");
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_backpressure();
    int p = 0;
    int w0 = writes_seen;
    start_frame(1, 4);
    for (int i = 0; i < 4; i++) exp_q.push_back(DATA_W'(32'h40 + i));
    for (int k = 0; k < 40 && p < 4; k++) begin
      s_axis_tvalid = (k % 2 == 0);
      img_full_n    = !(k >= 3 && k < 6);
      s_axis_tdata  = DATA_W'(32'h40 + p);
      s_axis_tlast  = (p == 3);
      @(negedge ap_clk);
      checks++;
      if (s_axis_tready !== img_full_n) begin
        errors++;
        $display("FAIL bp_tready: tready=%b expected %b (cycle %0d)", s_axis_tready, img_full_n, k);
      end
      if (img_write) p++;
      tick();
    end
    s_axis_tvalid = 1'b0;
    img_full_n    = 1'b1;
    checks++;
    if (writes_seen - w0 != 4) begin
      errors++;
      $display("FAIL bp_writes: img_write pulses=%0d expected 4", writes_seen - w0);
    end
    check_done_then_idle("backpressure");
  endtask

  task automatic test_hold_done();
    ap_continue = 1'b0;
    start_frame(1, 1);
    send_beat(24'h000050, 1'b1);
    load_dims(1, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      checks++;
      if (ap_done !== 1'b1 || rows_read !== 1'b0 || cols_read !== 1'b0 || s_axis_tready !== 1'b0) begin
        errors++;
        $display("FAIL hold_done: ap_done=%b rows_read=%b cols_read=%b tready=%b expected 1 0 0 0",
                 ap_done, rows_read, cols_read, s_axis_tready);
      end
      tick();
    end
    ap_continue = 1'b1;
    wait_pop();
    send_beat(24'h000051, 1'b1);
    check_done_then_idle("hold_done");
  endtask

  task automatic test_tlast_err();
    start_frame(1, 4);
    for (int i = 0; i < 4; i++) begin
      send_beat(DATA_W'(32'h60 + i), (i == 1));
      checks++;
      if (tlast_err !== (i >= 1) || ap_done !== (i == 3)) begin
        errors++;
        $display("FAIL tlast_err_beat%0d: tlast_err=%b ap_done=%b expected %b %b",
                 i + 1, tlast_err, ap_done, (i >= 1), (i == 3));
      end
    end
    check_done_then_idle("tlast_err");
  endtask

  task automatic test_async_reset();
    start_frame(3, 3);
    for (int i = 0; i < 4; i++) send_beat(DATA_W'(32'h70 + i), (i == 2));
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 24'h00007f;
    #2;
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if ({ap_done, ap_ready, rows_read, cols_read, s_axis_tready, img_write, tlast_err, ap_idle} !== 8'b0000_0001) begin
      errors++;
      $display("FAIL async_reset: done/ready/rr/cr/tready/wr/err/idle=%b expected 00000001",
               {ap_done, ap_ready, rows_read, cols_read, s_axis_tready, img_write, tlast_err, ap_idle});
    end
    s_axis_tvalid = 1'b0;
    @(posedge ap_clk); @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    start_frame(1, 1);
    send_beat(24'h000099, 1'b1);
    checks++;
    if (tlast_err !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_frame: tlast_err=%b pending=%0d expected 0 0", tlast_err, exp_q.size());
    end
    check_done_then_idle("post_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_rows();
    test_backpressure();
    test_hold_done();
    test_tlast_err();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
